// File: rtl/mux2_arbiter_pkg.sv
// Shared types and defaults for the two-source mux arbiter.
package mux2_arbiter_pkg;

  localparam int unsigned DATA_W        = 4;
  localparam int unsigned MAX_BEATS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  // Width of a counter that must hold 0..max_beats inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/mux2_arbiter_if.sv
// Two producer handshakes plus one consumer handshake around the shared mux.
interface mux2_arbiter_if
  import mux2_arbiter_pkg::*;
#(
  parameter int unsigned W = DATA_W
);

  logic [W-1:0] d0;
  logic         v0;
  logic         last0;
  logic         rdy0;
  logic [W-1:0] d1;
  logic         v1;
  logic         last1;
  logic         rdy1;
  logic [W-1:0] y;
  logic         y_valid;
  logic         y_last;
  logic         y_sel;
  logic         y_ready;

  // Environment side: drives producers and the consumer ready.
  modport master (
    output d0, v0, last0, d1, v1, last1, y_ready,
    input  rdy0, rdy1, y, y_valid, y_last, y_sel
  );

  // Arbiter side.
  modport slave (
    input  d0, v0, last0, d1, v1, last1, y_ready,
    output rdy0, rdy1, y, y_valid, y_last, y_sel
  );

endinterface

// File: rtl/mux2_arbiter_mux2_w.sv
// Plain W-bit 2:1 data select shared by both sources.
module mux2_w
  import mux2_arbiter_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  // sel_i = 1 picks source 1.
  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin, packet-locking arbiter in front of a shared mux, with a
// one-entry registered output stage toward the consumer.
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int unsigned W         = DATA_W,
  parameter int unsigned MAX_BEATS = MAX_BEATS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mux2_arbiter_if.slave    bus
);

  localparam int unsigned CW = cnt_w(MAX_BEATS);

  arb_state_t    state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  y_q, y_d;
  logic          y_valid_q, y_valid_d;
  logic          y_last_q, y_last_d;
  logic          y_sel_q, y_sel_d;

  logic          sel_c;
  logic [W-1:0]  mux_y_c;
  logic          out_free_c;
  logic          rdy0_c, rdy1_c;
  logic          src_v_c, src_last_c, xfer_last_c;

  mux2_w #(.W(W)) u_mux (
    .d0_i  (bus.d0),
    .d1_i  (bus.d1),
    .sel_i (sel_c),
    .y_o   (mux_y_c)
  );

  // Output slot can take a beat when empty or draining this cycle.
  assign out_free_c = !y_valid_q || bus.y_ready;

  // Grant selection, beat acceptance and output-stage load/drain.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    y_valid_d   = y_valid_q && !bus.y_ready;
    y_last_d    = y_last_q;
    y_sel_d     = y_sel_q;
    sel_c       = 1'b0;
    rdy0_c      = 1'b0;
    rdy1_c      = 1'b0;
    src_v_c     = 1'b0;
    src_last_c  = 1'b0;
    xfer_last_c = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.v0 && bus.v1) begin
          state_d = prio_q ? BUSY1 : BUSY0;
        end else if (bus.v0) begin
          state_d = BUSY0;
        end else if (bus.v1) begin
          state_d = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        sel_c      = (state_q == BUSY1);
        src_v_c    = sel_c ? bus.v1 : bus.v0;
        src_last_c = sel_c ? bus.last1 : bus.last0;
        rdy0_c     = !sel_c && out_free_c;
        rdy1_c     = sel_c && out_free_c;
        if (src_v_c && out_free_c) begin
          // Beat limit forces a release even without a source last.
          xfer_last_c = src_last_c || (cnt_q == CW'(MAX_BEATS - 1));
          y_d         = mux_y_c;
          y_sel_d     = sel_c;
          y_valid_d   = 1'b1;
          y_last_d    = xfer_last_c;
          cnt_d       = cnt_q + CW'(1);
          if (xfer_last_c) begin
            state_d = IDLE;
            prio_d  = !sel_c;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, priority, beat counter and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
      y_sel_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
      y_sel_q   <= y_sel_d;
    end
  end

  assign bus.rdy0    = rdy0_c;
  assign bus.rdy1    = rdy1_c;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_last  = y_last_q;
  assign bus.y_sel   = y_sel_q;

endmodule
